// File: rtl/traffic_light_scheduler_pkg.sv
// Shared traffic-light definitions: phase encodings, light indices, colour levels.
// Optional pedestrian phase enabled by defining PED_WALK_EN.
package traffic_pkg;

  typedef enum logic [2:0] {
    CLR_NS   = 3'd0,
    NS_GREEN = 3'd1,
    CLR_EW   = 3'd2,
`ifdef PED_WALK_EN
    EW_GREEN = 3'd3,
    WALK     = 3'd4
`else
    EW_GREEN = 3'd3
`endif
  } phase_e;

  localparam int unsigned LT_TOP   = 0;
  localparam int unsigned LT_RIGHT = 1;
  localparam int unsigned LT_DOWN  = 2;
  localparam int unsigned LT_LEFT  = 3;

  localparam logic GREEN = 1'b1;
  localparam logic RED   = 1'b0;

  // Light pattern shown while in a given phase; everything not green is red.
  function automatic logic [3:0] lights_for(input phase_e ph);
    logic [3:0] l;
    l = {4{RED}};
    case (ph)
      NS_GREEN: begin
        l[LT_TOP]  = GREEN;
        l[LT_DOWN] = GREEN;
      end
      EW_GREEN: begin
        l[LT_RIGHT] = GREEN;
        l[LT_LEFT]  = GREEN;
      end
      default: l = {4{RED}};
    endcase
    return l;
  endfunction

endpackage

// File: rtl/traffic_light_scheduler_if.sv
// Sensor/light bundle between the scheduler and its environment.
// ped_req/walk exist only when PED_WALK_EN is defined.
interface traffic_light_scheduler_if;
  logic [3:0] car_sense;
  logic       traffic0_color;
  logic       traffic1_color;
  logic       traffic2_color;
  logic       traffic3_color;
  logic [2:0] phase;
`ifdef PED_WALK_EN
  logic       ped_req;
  logic       walk;

  modport master (output car_sense, ped_req,
                  input  traffic0_color, traffic1_color, traffic2_color, traffic3_color,
                         phase, walk);
  modport slave  (input  car_sense, ped_req,
                  output traffic0_color, traffic1_color, traffic2_color, traffic3_color,
                         phase, walk);
`else
  modport master (output car_sense,
                  input  traffic0_color, traffic1_color, traffic2_color, traffic3_color,
                         phase);
  modport slave  (input  car_sense,
                  output traffic0_color, traffic1_color, traffic2_color, traffic3_color,
                         phase);
`endif
endinterface

// File: rtl/traffic_light_scheduler_tick_edge_timer.sv
// Slow-tick rising-edge detector plus saturating tick counter with synchronous clear.
module tick_edge_timer #(
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             tick_i,
  input  logic             clr_i,
  output logic             tick_p_o,
  output logic [CNT_W-1:0] cnt_o
);

  logic             tick_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick_p_o = tick_i & ~tick_q;
  assign cnt_o    = cnt_q;

  // Clear has priority; otherwise count ticks, holding at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (tick_p_o && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Tick history and counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tick_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      tick_q <= tick_i;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/traffic_light_scheduler.sv
// Four-way intersection scheduler: NS/EW right-of-way with all-red clearance,
// sensor-latched requests, min/max green timing in slow ticks.
// Optional pedestrian WALK phase enabled by defining PED_WALK_EN.
module traffic_light_scheduler
  import traffic_pkg::*;
#(
  parameter int unsigned MIN_GREEN   = 5,
  parameter int unsigned MAX_GREEN   = 15,
  parameter int unsigned CLEAR_TICKS = 2,
  parameter int unsigned WALK_TICKS  = 6,
  parameter int unsigned CNT_W       = 5
) (
  input  logic                      dclk,
  input  logic                      clr,
  input  logic                      tick,
  traffic_light_scheduler_if.slave  tl
);

  if ((MAX_GREEN >= 2**CNT_W) || (WALK_TICKS >= 2**CNT_W)) begin : g_bad_cfg
    $error("traffic_light_scheduler: MAX_GREEN and WALK_TICKS must be below 2**CNT_W");
  end

  localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MAX_LAST = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLEAR_TICKS - 1);

  phase_e           state_q, state_d;
  logic             tick_p;
  logic [CNT_W-1:0] cnt;
  logic             entering;
  logic             ns_req_q, ns_req_d;
  logic             ew_req_q, ew_req_d;
  logic             ns_end, ew_end;
  logic [3:0]       lights_q;

  tick_edge_timer #(.CNT_W(CNT_W)) u_timer (
    .clk_i    (dclk),
    .rst_i    (clr),
    .tick_i   (tick),
    .clr_i    (entering),
    .tick_p_o (tick_p),
    .cnt_o    (cnt)
  );

  assign entering = (state_d != state_q);

`ifdef PED_WALK_EN
  localparam logic [CNT_W-1:0] WALK_LAST = CNT_W'(WALK_TICKS - 1);

  logic ped_pend_q, ped_pend_d;
  logic last_ew_q, last_ew_d;
  logic walk_q;

  // A pending pedestrian can end a green on its own once minimum green is served.
  assign ns_end = (ew_req_q && (((cnt >= MIN_LAST) && !ns_req_q) || (cnt >= MAX_LAST)))
               || (ped_pend_q && (cnt >= MIN_LAST));
  assign ew_end = (ns_req_q && (((cnt >= MIN_LAST) && !ew_req_q) || (cnt >= MAX_LAST)))
               || (ped_pend_q && (cnt >= MIN_LAST));
`else
  // A green only yields to a cross request: after minimum green if own axis is idle, else at maximum.
  assign ns_end = ew_req_q && (((cnt >= MIN_LAST) && !ns_req_q) || (cnt >= MAX_LAST));
  assign ew_end = ns_req_q && (((cnt >= MIN_LAST) && !ew_req_q) || (cnt >= MAX_LAST));
`endif

  // Next-state selection; all transitions happen only on a tick edge.
  always_comb begin
    state_d = state_q;
    if (tick_p) begin
      case (state_q)
        CLR_NS:   if (cnt == CLR_LAST) state_d = NS_GREEN;
        CLR_EW:   if (cnt == CLR_LAST) state_d = EW_GREEN;
`ifdef PED_WALK_EN
        NS_GREEN: if (ns_end) state_d = ped_pend_q ? WALK : CLR_EW;
        EW_GREEN: if (ew_end) state_d = ped_pend_q ? WALK : CLR_NS;
        WALK:     if (cnt == WALK_LAST) state_d = last_ew_q ? CLR_NS : CLR_EW;
`else
        NS_GREEN: if (ns_end) state_d = CLR_EW;
        EW_GREEN: if (ew_end) state_d = CLR_NS;
`endif
        default:  state_d = CLR_NS;
      endcase
    end
  end

  // Request latches: the grant edge of an axis clears it, beating a same-cycle set.
  always_comb begin
    ns_req_d = ns_req_q | tl.car_sense[LT_TOP] | tl.car_sense[LT_DOWN];
    ew_req_d = ew_req_q | tl.car_sense[LT_RIGHT] | tl.car_sense[LT_LEFT];
    if (entering && (state_d == NS_GREEN)) ns_req_d = 1'b0;
    if (entering && (state_d == EW_GREEN)) ew_req_d = 1'b0;
  end

  // State, request and registered light outputs.
  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      state_q  <= CLR_NS;
      ns_req_q <= 1'b0;
      ew_req_q <= 1'b0;
      lights_q <= '0;
    end else begin
      state_q  <= state_d;
      ns_req_q <= ns_req_d;
      ew_req_q <= ew_req_d;
      lights_q <= lights_for(state_d);
    end
  end

`ifdef PED_WALK_EN
  // Pedestrian latch, cleared on WALK entry; remember which axis was last green.
  always_comb begin
    ped_pend_d = ped_pend_q | tl.ped_req;
    if (entering && (state_d == WALK)) ped_pend_d = 1'b0;
    last_ew_d = last_ew_q;
    if (state_q == NS_GREEN) last_ew_d = 1'b0;
    if (state_q == EW_GREEN) last_ew_d = 1'b1;
  end

  // Pedestrian state and registered walk indication.
  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      ped_pend_q <= 1'b0;
      last_ew_q  <= 1'b0;
      walk_q     <= 1'b0;
    end else begin
      ped_pend_q <= ped_pend_d;
      last_ew_q  <= last_ew_d;
      walk_q     <= (state_d == WALK);
    end
  end

  assign tl.walk = walk_q;
`endif

  assign tl.traffic0_color = lights_q[LT_TOP];
  assign tl.traffic1_color = lights_q[LT_RIGHT];
  assign tl.traffic2_color = lights_q[LT_DOWN];
  assign tl.traffic3_color = lights_q[LT_LEFT];
  assign tl.phase          = state_q;

endmodule

// File: tb/tb_traffic_light_scheduler.sv
// Directed bench for traffic_light_scheduler (default parameters).
module tb_traffic_light_scheduler;

  logic dclk = 1'b0;
  logic clr  = 1'b1;
  logic tick = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  logic [3:0] col;

  traffic_light_scheduler_if tl_if();

  traffic_light_scheduler #(
    .MIN_GREEN   (5),
    .MAX_GREEN   (15),
    .CLEAR_TICKS (2),
    .WALK_TICKS  (6),
    .CNT_W       (5)
  ) dut (
    .dclk (dclk),
    .clr  (clr),
    .tick (tick),
    .tl   (tl_if)
  );

  always #5 dclk = ~dclk;

  assign col = {tl_if.traffic3_color, tl_if.traffic2_color,
                tl_if.traffic1_color, tl_if.traffic0_color};

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_col(input int ph);
    if (ph == 1) return 4'b0101;
    if (ph == 3) return 4'b1010;
    return 4'b0000;
  endfunction

  task automatic check_state(input string tag, input int ph);
    check({tag, "_phase"}, {5'd0, tl_if.phase}, 8'(ph));
    check({tag, "_col"}, {4'd0, col}, {4'd0, exp_col(ph)});
  endtask

  task automatic step_tick();
    @(negedge dclk) tick = 1'b1;
    @(negedge dclk) tick = 1'b0;
    @(negedge dclk);
  endtask

  task automatic do_reset();
    @(negedge dclk);
    clr = 1'b1;
    tl_if.car_sense = 4'b0000;
`ifdef PED_WALK_EN
    tl_if.ped_req = 1'b0;
`endif
    @(negedge dclk);
    check_state("reset", 0);
    clr = 1'b0;
  endtask

  initial begin
    tl_if.car_sense = 4'b0000;
`ifdef PED_WALK_EN
    tl_if.ped_req = 1'b0;
`endif
    repeat (2) @(negedge dclk);
    check_state("por", 0);
`ifdef PED_WALK_EN
    check("por_walk", {7'd0, tl_if.walk}, 8'd0);
`endif
    clr = 1'b0;

    // Idle intersection: clearance then NS green forever.
    step_tick();
    check_state("idle_clr1", 0);
    step_tick();
    check_state("idle_grant", 1);
    repeat (40) step_tick();
    check_state("idle_40", 1);

    // EW car arrives while NS green with NS idle.
    do_reset();
    step_tick();
    step_tick();
    check_state("ew_pre", 1);
    @(negedge dclk) tl_if.car_sense = 4'b0010;
    for (int k = 1; k <= 7; k++) begin
      step_tick();
      check_state($sformatf("ew_arr_t%0d", k), (k <= 4) ? 1 : (k <= 6) ? 2 : 3);
    end

    // Asynchronous reset in the middle of EW green.
    #2 clr = 1'b1;
    #1 check_state("async_clr", 0);
    tl_if.car_sense = 4'b0000;
    @(negedge dclk) clr = 1'b0;
    step_tick();
    check_state("post_clr1", 0);
    step_tick();
    check_state("post_clr2", 1);

    // All sensors busy: max-green alternation, 34-tick period.
    do_reset();
    tl_if.car_sense = 4'b1111;
    step_tick();
    step_tick();
    check_state("busy_grant", 1);
    for (int k = 1; k <= 34; k++) begin
      step_tick();
      check_state($sformatf("busy_t%0d", k),
                  (k <= 14) ? 1 : (k <= 16) ? 2 : (k <= 31) ? 3 : (k <= 33) ? 0 : 1);
    end

    // One-cycle NS sensor pulse on the NS grant edge must not leave a request.
    do_reset();
    step_tick();
    @(negedge dclk) begin
      tick = 1'b1;
      tl_if.car_sense = 4'b0001;
    end
    @(negedge dclk) begin
      tick = 1'b0;
      tl_if.car_sense = 4'b0000;
    end
    @(negedge dclk);
    check_state("pulse_grant", 1);
    @(negedge dclk) tl_if.car_sense = 4'b0010;
    @(negedge dclk) tl_if.car_sense = 4'b0000;
    for (int k = 1; k <= 7; k++) begin
      step_tick();
      check_state($sformatf("pulse_t%0d", k), (k <= 4) ? 1 : (k <= 6) ? 2 : 3);
    end
    repeat (20) step_tick();
    check_state("pulse_hold", 3);

`ifdef PED_WALK_EN
    // Pedestrian press at NS tick 2: WALK after minimum green, then EW.
    do_reset();
    step_tick();
    step_tick();
    step_tick();
    step_tick();
    @(negedge dclk) tl_if.ped_req = 1'b1;
    @(negedge dclk) tl_if.ped_req = 1'b0;
    for (int k = 3; k <= 13; k++) begin
      step_tick();
      check_state($sformatf("walk_t%0d", k),
                  (k <= 4) ? 1 : (k <= 10) ? 4 : (k <= 12) ? 2 : 3);
      check($sformatf("walk_t%0d_w", k), {7'd0, tl_if.walk},
            ((k >= 5) && (k <= 10)) ? 8'd1 : 8'd0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
